// File: rtl/step_judge_pkg.sv
// Shared verdict/state encodings, arrow bit positions and the saturating score adder.
package step_judge_pkg;

    typedef enum logic [1:0] {
        MISS    = 2'd0,
        GOOD    = 2'd1,
        PERFECT = 2'd2
    } judge_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam int ARW_L = 3;
    localparam int ARW_D = 2;
    localparam int ARW_U = 1;
    localparam int ARW_R = 0;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/step_judge_if.sv
// Chart/pad inputs and verdict/score outputs of the step judge.
interface step_judge_if;
    import step_judge_pkg::*;

    logic        sixteenth_i;
    logic        note_valid_i;
    logic [3:0]  note_arrows_i;
    logic [3:0]  btn_i;
    logic        judge_valid_o;
    judge_t      judge_o;
    logic [15:0] score_o;
    logic [7:0]  combo_o;
    logic [7:0]  max_combo_o;

    modport master (
        output sixteenth_i, note_valid_i, note_arrows_i, btn_i,
        input  judge_valid_o, judge_o, score_o, combo_o, max_combo_o
    );

    modport slave (
        input  sixteenth_i, note_valid_i, note_arrows_i, btn_i,
        output judge_valid_o, judge_o, score_o, combo_o, max_combo_o
    );
endinterface

// File: rtl/step_judge_btn_edge.sv
// Rising-edge detector for the four arrow pads; combinational edges, 1 register stage.
// No backpressure. History resets to all-ones so pads held through reset give no edge.
module btn_edge (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] btn_i,
    output logic [3:0] edges_o
);
    logic [3:0] btn_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) btn_q <= 4'hF;
        else         btn_q <= btn_i;
    end

    assign edges_o = btn_i & ~btn_q;
endmodule

// File: rtl/step_judge.sv
// Times note completion against PERFECT/GOOD windows and keeps score/combo.
// Verdict registered 1 cycle after the deciding cycle; no backpressure, one verdict per cycle.
module step_judge
    import step_judge_pkg::*;
#(
    parameter int unsigned PERFECT_CYC = 315000,
    parameter int unsigned GOOD_CYC    = 787500,
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned PERFECT_PTS = 3,
    parameter int unsigned GOOD_PTS    = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    step_judge_if.slave bus
);
    state_t             state_q, state_d;
    logic [3:0]         need_q, need_d, hit_q, hit_d;
    logic [CNT_W-1:0]   e_q, e_d;
    logic [3:0]         edges, arm_hit, hit_n;
    logic               arm, done, vld_d;
    judge_t             verdict_d;
    logic [7:0]         combo_n;
    logic [15:0]        pts;

    btn_edge u_btn_edge (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_i   (bus.btn_i),
        .edges_o (edges)
    );

    assign arm     = bus.sixteenth_i & bus.note_valid_i & (bus.note_arrows_i != 4'h0);
    assign arm_hit = edges & bus.note_arrows_i;
    assign hit_n   = hit_q | (edges & need_q);
    assign done    = (hit_n == need_q);

    always_comb begin
        state_d   = state_q;
        need_d    = need_q;
        hit_d     = hit_q;
        e_d       = e_q;
        vld_d     = 1'b0;
        verdict_d = MISS;
        case (state_q)
            IDLE: begin
                // A note fully hit on its own strobe is graded at once and never arms.
                if (arm && (arm_hit == bus.note_arrows_i)) begin
                    vld_d     = 1'b1;
                    verdict_d = PERFECT;
                end else if (arm) begin
                    state_d = ARMED;
                    need_d  = bus.note_arrows_i;
                    hit_d   = arm_hit;
                    e_d     = '0;
                end
            end
            ARMED: begin
                if (done) begin
                    vld_d     = 1'b1;
                    verdict_d = (e_q < CNT_W'(PERFECT_CYC)) ? PERFECT :
                                (e_q < CNT_W'(GOOD_CYC))    ? GOOD : MISS;
                end else if (arm || (e_q == CNT_W'(GOOD_CYC - 1))) begin
                    vld_d     = 1'b1;
                    verdict_d = MISS;
                end
                // A new note replaces the pending one; a full hit on it is graded next cycle at e=0.
                if (arm) begin
                    need_d = bus.note_arrows_i;
                    hit_d  = arm_hit;
                    e_d    = '0;
                end else if (vld_d) begin
                    state_d = IDLE;
                    need_d  = 4'h0;
                    hit_d   = 4'h0;
                    e_d     = '0;
                end else begin
                    e_d   = e_q + 1'b1;
                    hit_d = hit_n;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pts     = (verdict_d == PERFECT) ? 16'(PERFECT_PTS) :
                  (verdict_d == GOOD)    ? 16'(GOOD_PTS)    : 16'h0;
        combo_n = (verdict_d == MISS)    ? 8'h00 :
                  (bus.combo_o == 8'hFF) ? 8'hFF : bus.combo_o + 8'h01;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q           <= IDLE;
            need_q            <= 4'h0;
            hit_q             <= 4'h0;
            e_q               <= '0;
            bus.judge_valid_o <= 1'b0;
            bus.judge_o       <= MISS;
            bus.score_o       <= 16'h0;
            bus.combo_o       <= 8'h0;
            bus.max_combo_o   <= 8'h0;
        end else begin
            state_q           <= state_d;
            need_q            <= need_d;
            hit_q             <= hit_d;
            e_q               <= e_d;
            bus.judge_valid_o <= vld_d;
            if (vld_d) begin
                bus.judge_o     <= verdict_d;
                bus.score_o     <= sat_add16(bus.score_o, pts);
                bus.combo_o     <= combo_n;
                bus.max_combo_o <= (combo_n > bus.max_combo_o) ? combo_n : bus.max_combo_o;
            end
        end
    end
endmodule

// File: tb/tb_step_judge.sv
// Directed bench for step_judge with short windows (PERFECT 4, GOOD 10 cycles).
module tb_step_judge;
    import step_judge_pkg::*;

    localparam logic [3:0] A_L = 4'(1 << ARW_L);
    localparam logic [3:0] A_D = 4'(1 << ARW_D);
    localparam logic [3:0] A_U = 4'(1 << ARW_U);
    localparam logic [3:0] A_R = 4'(1 << ARW_R);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    step_judge_if bus();

    step_judge #(
        .PERFECT_CYC (4),
        .GOOD_CYC    (10),
        .CNT_W       (20),
        .PERFECT_PTS (3),
        .GOOD_PTS    (1)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [3:0] arr, input logic [3:0] b);
        bus.sixteenth_i   = 1'b1;
        bus.note_valid_i  = 1'b1;
        bus.note_arrows_i = arr;
        bus.btn_i         = b;
        tick();
        bus.sixteenth_i   = 1'b0;
        bus.note_valid_i  = 1'b0;
        bus.note_arrows_i = 4'h0;
    endtask

    // Arm a note, complete it at e=4 (inside GOOD, outside PERFECT), release.
    task automatic good_hit(input logic [3:0] a, output logic got_good);
        arm(a, 4'h0);
        repeat (4) tick();
        bus.btn_i = a;
        tick();
        got_good = bus.judge_valid_o && (bus.judge_o == GOOD);
        bus.btn_i = 4'h0;
        tick();
    endtask

    initial begin
        int    pulses;
        int    goods;
        logic  g;
        logic [3:0] arr;

        bus.sixteenth_i   = 1'b0;
        bus.note_valid_i  = 1'b0;
        bus.note_arrows_i = 4'h0;
        bus.btn_i         = 4'h0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_valid", bus.judge_valid_o, 0);
        chk("rst_judge", bus.judge_o, 0);
        chk("rst_score", bus.score_o, 0);
        chk("rst_combo", bus.combo_o, 0);
        chk("rst_max",   bus.max_combo_o, 0);
        tick();

        // PERFECT: edge for L at e=2
        arm(A_L, 4'h0);
        tick();
        tick();
        bus.btn_i = A_L;
        tick();
        chk("p1_valid", bus.judge_valid_o, 1);
        chk("p1_judge", bus.judge_o, PERFECT);
        chk("p1_score", bus.score_o, 3);
        chk("p1_combo", bus.combo_o, 1);
        bus.btn_i = 4'h0;
        tick();
        chk("p1_pulse_one_cycle", bus.judge_valid_o, 0);

        // GOOD: U at e=1, R at e=6
        arm(A_U | A_R, 4'h0);
        tick();
        bus.btn_i = A_U;
        tick();
        repeat (4) tick();
        bus.btn_i = A_U | A_R;
        tick();
        chk("g1_valid", bus.judge_valid_o, 1);
        chk("g1_judge", bus.judge_o, GOOD);
        chk("g1_score", bus.score_o, 4);
        chk("g1_combo", bus.combo_o, 2);
        bus.btn_i = 4'h0;
        tick();

        // MISS exactly 10 cycles after arming when only U is pressed
        arm(A_U | A_R, 4'h0);
        bus.btn_i = A_U;
        repeat (9) tick();
        chk("m1_not_early", bus.judge_valid_o, 0);
        tick();
        chk("m1_valid", bus.judge_valid_o, 1);
        chk("m1_judge", bus.judge_o, MISS);
        chk("m1_combo", bus.combo_o, 0);
        chk("m1_score", bus.score_o, 4);
        chk("m1_max",   bus.max_combo_o, 2);
        bus.btn_i = 4'h0;
        tick();

        // Reset mid-window with D held through release
        arm(A_L, 4'h0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst2_score", bus.score_o, 0);
        chk("rst2_max",   bus.max_combo_o, 0);
        bus.btn_i = A_D;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst2_no_verdict", bus.judge_valid_o, 0);
        arm(A_D, A_D);
        repeat (9) tick();
        chk("held_not_early", bus.judge_valid_o, 0);
        tick();
        chk("held_valid", bus.judge_valid_o, 1);
        chk("held_judge", bus.judge_o, MISS);
        bus.btn_i = 4'h0;
        tick();
        arm(A_D, 4'h0);
        bus.btn_i = A_D;
        tick();
        chk("repress_judge", bus.judge_o, PERFECT);
        chk("repress_valid", bus.judge_valid_o, 1);
        chk("repress_score", bus.score_o, 3);
        chk("repress_combo", bus.combo_o, 1);
        bus.btn_i = 4'h0;
        tick();

        // Second strobe at e=5 with note 1 incomplete
        arm(A_L, 4'h0);
        repeat (5) tick();
        arm(A_R, 4'h0);
        chk("re_arm_valid", bus.judge_valid_o, 1);
        chk("re_arm_judge", bus.judge_o, MISS);
        chk("re_arm_combo", bus.combo_o, 0);
        chk("re_arm_max",   bus.max_combo_o, 1);
        tick();
        tick();
        bus.btn_i = A_R;
        tick();
        chk("n2_valid", bus.judge_valid_o, 1);
        chk("n2_judge", bus.judge_o, PERFECT);
        chk("n2_score", bus.score_o, 6);
        chk("n2_max",   bus.max_combo_o, 1);
        bus.btn_i = 4'h0;
        tick();

        // Completion on the arming strobe itself
        arm(A_U, A_U);
        chk("same_cyc_valid", bus.judge_valid_o, 1);
        chk("same_cyc_judge", bus.judge_o, PERFECT);
        chk("same_cyc_score", bus.score_o, 9);
        chk("same_cyc_max",   bus.max_combo_o, 2);
        bus.btn_i = 4'h0;
        tick();

        // Idle edges and unstrobed notes give nothing
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            bus.btn_i         = (i % 2 == 0) ? 4'hF : 4'h0;
            bus.note_valid_i  = 1'b1;
            bus.note_arrows_i = 4'hF;
            tick();
            pulses += int'(bus.judge_valid_o);
        end
        bus.btn_i         = 4'h0;
        bus.note_valid_i  = 1'b0;
        bus.note_arrows_i = 4'h0;
        tick();
        pulses += int'(bus.judge_valid_o);
        chk("idle_pulses", pulses, 0);
        chk("idle_score", bus.score_o, 9);
        chk("idle_combo", bus.combo_o, 2);

        // Preload: 21841 PERFECTs take score 9 -> 65532
        for (int k = 0; k < 21841; k++) begin
            arr = (k % 2 == 0) ? A_L : A_D;
            arm(arr, arr);
        end
        bus.btn_i = 4'h0;
        tick();
        chk("pre_score", bus.score_o, 65532);
        chk("pre_combo", bus.combo_o, 255);
        good_hit(A_L, g);
        chk("pre_good1", g, 1);
        good_hit(A_D, g);
        chk("pre_good2", g, 1);
        chk("pre_score2", bus.score_o, 65534);
        arm(A_U, A_U);
        chk("sat_score", bus.score_o, 65535);
        chk("sat_combo", bus.combo_o, 255);
        bus.btn_i = 4'h0;
        tick();

        arm(A_L, 4'h0);
        repeat (10) tick();
        chk("clr_combo", bus.combo_o, 0);
        chk("clr_max",   bus.max_combo_o, 255);

        goods = 0;
        for (int k = 0; k < 300; k++) begin
            good_hit((k % 2 == 0) ? A_R : A_U, g);
            goods += int'(g);
        end
        chk("goods_count", goods, 300);
        chk("goods_combo", bus.combo_o, 255);
        chk("goods_max",   bus.max_combo_o, 255);
        chk("goods_score", bus.score_o, 65535);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/step_judge.md
# step_judge

Beat-synchronous hit judge for the dance game: it consumes the `sixteenth` beat strobe from the timing generator together with the chart's note for that slot and the player's arrow pads. It times each note's completion against a two-level window and emits a PERFECT/GOOD/MISS verdict plus running score and combo. It sits between the timing/chart logic and the display/scoreboard logic.

## Interface
- `PERFECT_CYC`, default 315000: cycles after arming in which completion grades PERFECT (50 ms at 6.3 MHz).
- `GOOD_CYC`, default 787500: cycles after arming in which completion grades GOOD; must be > `PERFECT_CYC`.
- `CNT_W`, default 20: elapsed-counter width; `GOOD_CYC` must be < 2^`CNT_W`.
- `PERFECT_PTS`, default 3: score added per PERFECT.
- `GOOD_PTS`, default 1: score added per GOOD.
- `clk_i` in 1: single clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `sixteenth_i` in 1: one-cycle beat strobe from the timing generator.
- `note_valid_i` in 1: chart has a note in the current slot; qualified by `sixteenth_i`.
- `note_arrows_i` in 4: required arrows {L,D,U,R}; all-zero means no note.
- `btn_i` in 4: synchronized, debounced pad levels, 1 = pressed.
- `judge_valid_o` out 1: one-cycle verdict strobe.
- `judge_o` out 2: verdict, valid with `judge_valid_o`.
- `score_o` out 16: accumulated score, saturating.
- `combo_o` out 8: current combo, saturating.
- `max_combo_o` out 8: best combo since reset.

## Operation
- Press detection: `edges = btn_i & ~btn_q`, where `btn_q` is the registered `btn_i`. `btn_q` resets to 4'hF, so pads held through reset produce no edge.
- Arm condition: `sixteenth_i & note_valid_i & (note_arrows_i != 0)`.
- FSM, two states:
  - IDLE: edges are ignored. On the arm condition, load `need = note_arrows_i`, `hit = edges & note_arrows_i`, `e = 0`, then go to ARMED.
  - ARMED: `hit_n = hit | (edges & need)`. Completion means `hit_n == need`.
    - On completion with `e < PERFECT_CYC`: PERFECT.
    - On completion with `e < GOOD_CYC`: GOOD.
    - Otherwise, when `e == GOOD_CYC-1` without completion: MISS.
    - After any verdict, go to IDLE. Otherwise `e <= e + 1` and `hit <= hit_n`.
- Extra arrows not in `need` are ignored and do not penalize.
- Completion in the arming cycle itself (all arrows' edges coincide with the strobe) is evaluated with `e = 0` and gives PERFECT.
- Arm condition while ARMED:
  - If the pending note completes in that same cycle, it receives its normal grade. Otherwise it is judged MISS.
  - In both cases the new note is armed exactly as from IDLE (edges in that cycle count toward both notes), and the FSM stays ARMED.
- Verdict also fires if `e` reaches the limit: MISS takes priority only when completion is absent.
- Score: PERFECT adds `PERFECT_PTS`, GOOD adds `GOOD_PTS`, MISS adds 0. Addition saturates at 16'hFFFF.
- Combo: +1 on PERFECT/GOOD, saturating at 255. It is cleared to 0 on MISS.
- Max combo: `max_combo_o <= max(max_combo_o, new combo)`.

## Timing
- Reset (async assert, sync release) puts the block in IDLE. All outputs are 0, `need`/`hit`/`e` are 0, and `btn_q` = 4'hF.
- Verdict latency: `judge_valid_o` and `judge_o` are registered and appear on the clock edge after the deciding cycle, i.e. 1 cycle after the completing edge is sampled.
- `score_o`, `combo_o` and `max_combo_o` update on the same edge as `judge_valid_o`. `max_combo_o` reflects the new combo in that cycle.
- `judge_valid_o` is high for exactly one cycle. There are at most one verdict per cycle and at most one outstanding note.
- MISS for an unanswered note asserts exactly `GOOD_CYC` cycles after the arming edge.
- Reset mid-window discards the pending note without a verdict.
- `e` never wraps, because it is bounded by `GOOD_CYC-1`.

## Structure
- `step_judge_pkg`:
  - `judge_t` enum (2 bits): MISS=0, GOOD=1, PERFECT=2; value 3 is unused.
  - `state_t` enum: IDLE, ARMED.
  - Arrow bit-index constants L=3, D=2, U=1, R=0.
- Sub-module `btn_edge`: 4-bit rising-edge detector with the reset-to-ones register.
- The FSM, the counter and the score/combo datapath stay in `step_judge`.

## Test plan
The bench uses `PERFECT_CYC=4`, `GOOD_CYC=10`.
- Arm {L} (4'b1000), rise L 2 cycles later → one cycle later `judge_o`=PERFECT, `score_o`=3, `combo_o`=1.
- Arm {U,R}, rise U at e=1 and R at e=6 → GOOD, `score_o` +1, combo +1. Pressing only U → MISS exactly 10 cycles after arming, `combo_o`=0.
- Hold D through reset release, then arm {D} without re-pressing → MISS (no spurious edge). Re-press D in the next window → PERFECT.
- Second arm strobe at e=5 with the first note incomplete → MISS for note 1, note 2 armed. Edge for note 2 at its e=2 → PERFECT. `max_combo_o` is kept.
- Preload the score near saturation (65534) via repeated hits → the next PERFECT holds `score_o`=65535. 300 consecutive GOODs → `combo_o`=255 and `max_combo_o`=255.
- Edges while IDLE and `note_valid_i` without `sixteenth_i` → no `judge_valid_o`, outputs unchanged.
